// File: rtl/fetch_prefetch_unit.sv
// Decoupled instruction-fetch front end: pipelined imem requests, an in-order
// PC/instruction queue towards decode, and redirect flush with stale-response dropping.
module fetch_prefetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     dbg_redirect_misaligned
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 4;
    localparam logic [PW-1:0]   PTR_ONE   = 1;
    localparam logic [PW:0]     SUM_ONE   = 1;
    localparam logic [PW:0]     DEPTH_W   = DEPTH[PW:0];

    logic                started_q, started_d;
    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]       alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]       fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       drop_cnt_q, drop_cnt_d;
    logic                dbg_mis_q, dbg_mis_d;
    logic [XLEN-1:0]     pc_mem_q [DEPTH];
    logic [XLEN-1:0]     pc_mem_d [DEPTH];
    logic [31:0]         instr_mem_q [DEPTH];
    logic [31:0]         instr_mem_d [DEPTH];

    logic [PW-1:0]       alloc_cnt;
    logic [PW-1:0]       live_cnt;
    logic [PW:0]         budget;
    logic [PW:0]         drop_sum;
    logic                req_fire;
    logic                rsp_drop;
    logic                rsp_fill;
    logic                rsp_err;
    logic                out_fire;

    // Allocated entries plus responses still owed to a flushed stream bound new requests.
    assign alloc_cnt = alloc_ptr_q - rd_ptr_q;
    assign live_cnt  = alloc_ptr_q - fill_ptr_q;
    assign budget    = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};

    assign imem_req_valid = started_q & ~redirect_valid & (budget < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
    assign rsp_err  = imem_rsp_valid & (drop_cnt_q == '0) & (live_cnt == '0);
    assign rsp_fill = imem_rsp_valid & (drop_cnt_q == '0) & (live_cnt != '0) & ~redirect_valid;

    assign out_valid = (fill_ptr_q != rd_ptr_q);
    assign out_pc    = pc_mem_q[rd_ptr_q[IW-1:0]];
    assign out_instr = instr_mem_q[rd_ptr_q[IW-1:0]];
    assign out_fire  = out_valid & out_ready;

    assign occupancy               = alloc_cnt;
    assign dbg_redirect_misaligned = dbg_mis_q;

    always_comb begin
        started_d   = 1'b1;
        fetch_pc_d  = fetch_pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drop_cnt_d  = drop_cnt_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        dbg_mis_d   = redirect_valid & (|redirect_pc[1:0]);
        drop_sum    = {1'b0, drop_cnt_q} + {1'b0, live_cnt};

        if (redirect_valid) begin
            // Every live request becomes stale; a response arriving now is one of them.
            if (imem_rsp_valid && (drop_sum != '0)) begin
                drop_sum = drop_sum - SUM_ONE;
            end
            drop_cnt_d  = drop_sum[PW-1:0];
            alloc_ptr_d = rd_ptr_q;
            fill_ptr_d  = rd_ptr_q;
            fetch_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (req_fire) begin
                pc_mem_d[alloc_ptr_q[IW-1:0]] = fetch_pc_q;
                alloc_ptr_d                   = alloc_ptr_q + PTR_ONE;
                fetch_pc_d                    = fetch_pc_q + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - PTR_ONE;
            end
            if (rsp_fill) begin
                instr_mem_d[fill_ptr_q[IW-1:0]] = imem_rsp_data;
                fill_ptr_d                      = fill_ptr_q + PTR_ONE;
            end
            if (out_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q   <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            drop_cnt_q  <= '0;
            dbg_mis_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= NOP_INSTR;
            end
        end else begin
            started_q   <= started_d;
            fetch_pc_q  <= fetch_pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            dbg_mis_q   <= dbg_mis_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    // A response with nothing outstanding means the memory and this block disagree.
    rsp_protocol_check : assert property (@(posedge clk) disable iff (!rst_n) !rsp_err);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios plus randomized traffic, checked
// against an architectural fetch-stream model through an expected-output queue.
module tb_fetch_prefetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;
    logic        dbg_redirect_misaligned;

    fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .imem_req_valid          (imem_req_valid),
        .imem_req_ready          (imem_req_ready),
        .imem_req_addr           (imem_req_addr),
        .imem_rsp_valid          (imem_rsp_valid),
        .imem_rsp_data           (imem_rsp_data),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_pc                  (out_pc),
        .out_instr               (out_instr),
        .occupancy               (occupancy),
        .dbg_redirect_misaligned (dbg_redirect_misaligned)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: in-order responses, per-request latency in [lat_min, lat_max]
    int          lat_min = 1;
    int          lat_max = 1;
    longint      cyc = 0;
    longint      last_due = 0;
    logic [31:0] pend_addr[$];
    longint      pend_due[$];

    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            longint due;
            due = cyc + longint'($urandom_range(lat_min, lat_max));
            if (due < last_due) due = last_due;
            last_due = due;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            last_due = 0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Reference model: the architectural fetch stream is sequential words from the
    // last reset/redirect target; exp_q holds the next outputs decode must see.
    logic [63:0] exp_q[$];
    logic [31:0] next_exp;
    logic [31:0] req_model_pc;
    int          model_occ = 0;
    bit          mis_prev = 0;
    int          req_cnt = 0;
    int          pop_cnt = 0;

    task automatic model_restart(input logic [31:0] target);
        exp_q.delete();
        next_exp     = {target[31:2], 2'b00};
        req_model_pc = next_exp;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({next_exp, mem_word(next_exp)});
            next_exp = next_exp + 32'd4;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            model_occ = 0;
            mis_prev  = 0;
        end else begin
            logic [63:0] e;
            check("occupancy", 64'(occupancy), 64'(model_occ));
            check("dbg_misaligned", 64'(dbg_redirect_misaligned), 64'(mis_prev));
            if (redirect_valid) check("req_in_redirect", 64'(imem_req_valid), 64'd0);
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", 64'(imem_req_addr), 64'(req_model_pc));
                req_model_pc = req_model_pc + 32'd4;
                req_cnt++;
                model_occ++;
            end
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got pc 0x%0h expected none", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", 64'(out_pc), 64'(e[63:32]));
                    check("out_instr", 64'(out_instr), 64'(e[31:0]));
                    exp_q.push_back({next_exp, mem_word(next_exp)});
                    next_exp = next_exp + 32'd4;
                end
                model_occ--;
                pop_cnt++;
            end
            if (redirect_valid) model_occ = 0;
            mis_prev = redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_req_addr"}, 64'(imem_req_addr), 64'(RESET_PC));
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
        check({tag, "_out_instr"}, 64'(out_instr), 64'h13);
        check({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        check({tag, "_dbg"}, 64'(dbg_redirect_misaligned), 64'd0);
    endtask

    // Leaves rst_n released at the start of "cycle 0".
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_restart(RESET_PC);
        tick();
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_out_valid(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else tick();
        end
        if (!seen) check(name, 64'd0, 64'd1);
    endtask

    initial begin
        int start_cnt;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Sequential fetch, 1-cycle memory
        do_reset();
        @(negedge clk); check("t1_c0_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); @(negedge clk);
        check("t1_c1_req_valid", 64'(imem_req_valid), 64'd1);
        check("t1_c1_addr", 64'(imem_req_addr), 64'h0);
        check("t1_c1_out_valid", 64'(out_valid), 64'd0);
        tick(); @(negedge clk);
        check("t1_c2_addr", 64'(imem_req_addr), 64'h4);
        check("t1_c2_out_valid", 64'(out_valid), 64'd0);
        tick(); @(negedge clk);
        check("t1_c3_addr", 64'(imem_req_addr), 64'h8);
        check("t1_c3_out_valid", 64'(out_valid), 64'd1);
        check("t1_c3_out_pc", 64'(out_pc), 64'h0);
        check("t1_c3_out_instr", 64'(out_instr), 64'(mem_word(32'h0)));
        tick(); @(negedge clk);
        check("t1_c4_out_pc", 64'(out_pc), 64'h4);
        tick(); @(negedge clk);
        check("t1_c5_out_pc", 64'(out_pc), 64'h8);

        // Full queue with decode stalled, then one pop
        out_ready = 1'b0;
        do_reset();
        start_cnt = req_cnt;
        repeat (10) tick();
        @(negedge clk);
        check("t2_req_count", 64'(req_cnt - start_cnt), 64'd4);
        check("t2_full_req_valid", 64'(imem_req_valid), 64'd0);
        check("t2_full_occupancy", 64'(occupancy), 64'd4);
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        @(negedge clk);
        check("t2_resume_req_valid", 64'(imem_req_valid), 64'd1);
        check("t2_resume_addr", 64'(imem_req_addr), 64'h10);

        // Redirect with two requests in flight, 3-cycle memory
        out_ready = 1'b1;
        lat_min = 3; lat_max = 3;
        do_reset();
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100; model_restart(32'h100);
        @(negedge clk);
        check("t3_redirect_req_valid", 64'(imem_req_valid), 64'd0);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_target_addr", 64'(imem_req_addr), 64'h100);
        wait_out_valid("t3_wait_out_valid", 20);
        check("t3_first_out_pc", 64'(out_pc), 64'h100);
        check("t3_first_out_instr", 64'(out_instr), 64'(mem_word(32'h100)));

        // Redirect coinciding with a response and an output handshake
        lat_min = 1; lat_max = 1;
        do_reset();
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300; model_restart(32'h300);
        @(negedge clk);
        check("t4_redir_out_valid", 64'(out_valid), 64'd1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_occupancy", 64'(occupancy), 64'd0);
        check("t4_req_valid", 64'(imem_req_valid), 64'd1);
        check("t4_req_addr", 64'(imem_req_addr), 64'h300);
        check("t4_out_valid", 64'(out_valid), 64'd0);
        repeat (6) tick();

        // Misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h202; model_restart(32'h202);
        @(negedge clk);
        check("t5_dbg_c0", 64'(dbg_redirect_misaligned), 64'd0);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_dbg_c1", 64'(dbg_redirect_misaligned), 64'd1);
        check("t5_addr", 64'(imem_req_addr), 64'h200);
        tick(); @(negedge clk);
        check("t5_dbg_c2", 64'(dbg_redirect_misaligned), 64'd0);
        repeat (6) tick();

        // Memory stall, then reset mid-stream
        imem_req_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick(); @(negedge clk);
            check("t6_stall_valid", 64'(imem_req_valid), 64'd1);
            check("t6_stall_addr", 64'(imem_req_addr), 64'h0);
        end
        tick(); imem_req_ready = 1'b1;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_midreset");
        do_reset();

        // Randomized traffic
        lat_min = 1; lat_max = 4;
        start_cnt = pop_cnt;
        for (int i = 0; i < 3000; i++) begin
            tick();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom & 32'h0000_0FFF;
                model_restart(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (40) tick();
        @(negedge clk);
        check("rand_progress", 64'(pop_cnt - start_cnt > 500), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
